// File: rtl/job_arbiter.sv
// Round-robin arbiter that shares one job unit among NUM_REQ requesters.
// One job at most is in flight: IDLE grants, BUSY waits for the unit result,
// DONE presents the result to the owning requester until it takes it.
//
//   state | meaning
//   IDLE  | no job; grant first requester at/after ptr when unit is ready
//   BUSY  | job issued to unit; waiting for unit result
//   DONE  | result held for owner; cleared when owner takes it
module job_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4,
   localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ-1:0]            req_start_en_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_start_data_i,
   output logic [NUM_REQ-1:0]            req_start_rdy_o,
   input  logic [NUM_REQ-1:0]            req_getResult_en_i,
   output logic [NUM_REQ-1:0]            req_getResult_rdy_o,
   output logic [DATA_WIDTH-1:0]         req_getResult_data_o,
   output logic                          unit_start_en_o,
   output logic [DATA_WIDTH-1:0]         unit_start_data_o,
   input  logic                          unit_start_rdy_i,
   output logic                          unit_getResult_en_o,
   input  logic                          unit_getResult_rdy_i,
   input  logic [DATA_WIDTH-1:0]         unit_getResult_data_i,
   output logic                          busy_o,
   output logic [IDX_W-1:0]              owner_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [DATA_WIDTH-1:0]  result_q, result_d;
   logic [NUM_REQ-1:0]     get_rdy_q, get_rdy_d;
   logic                   busy_q, busy_d;

   logic [IDX_W-1:0]       win;
   logic                   win_vld;
   logic                   grant;
   logic [IDX_W:0]         sum;

   // Round-robin search: first active request at index ptr, ptr+1, ... wrapping.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      sum     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
         end
         if (!win_vld && req_start_en_i[sum[IDX_W-1:0]]) begin
            win_vld = 1'b1;
            win     = sum[IDX_W-1:0];
         end
      end
   end

   // Combinational handshakes toward requesters and unit; suppressed while in reset.
   always_comb begin
      grant               = (state_q == ST_IDLE) && win_vld && unit_start_rdy_i && !rst_i;
      req_start_rdy_o     = grant ? (NUM_REQ'(1) << win) : '0;
      unit_start_en_o     = grant;
      unit_start_data_o   = grant ? req_start_data_i[win*DATA_WIDTH +: DATA_WIDTH] : '0;
      unit_getResult_en_o = (state_q == ST_BUSY) && unit_getResult_rdy_i && !rst_i;
   end

   // Next-state logic; registered outputs derive from the next state so they
   // line up with the state they describe.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               owner_d = win;
               ptr_d   = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (unit_getResult_rdy_i) begin
               result_d = unit_getResult_data_i;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (req_getResult_en_i[owner_q]) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d    = (state_d != ST_IDLE);
      get_rdy_d = (state_d == ST_DONE) ? (NUM_REQ'(1) << owner_d) : '0;
   end

   // State and registered outputs; reset abandons any job in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         result_q  <= '0;
         get_rdy_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         result_q  <= result_d;
         get_rdy_q <= get_rdy_d;
         busy_q    <= busy_d;
      end
   end

   assign req_getResult_rdy_o  = get_rdy_q;
   assign req_getResult_data_o = result_q;
   assign busy_o               = busy_q;
   assign owner_o              = owner_q;

endmodule

// File: tb/tb_job_arbiter.sv
// Bench for job_arbiter: directed scenarios followed by randomized traffic,
// checked against a job-level reference model (grant rule, job phase, result).
module tb_job_arbiter;
   localparam int N = 4;
   localparam int W = 32;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [N-1:0]     req_start_en_i;
   logic [N*W-1:0]   req_start_data_i;
   logic [N-1:0]     req_start_rdy_o;
   logic [N-1:0]     req_getResult_en_i;
   logic [N-1:0]     req_getResult_rdy_o;
   logic [W-1:0]     req_getResult_data_o;
   logic             unit_start_en_o;
   logic [W-1:0]     unit_start_data_o;
   logic             unit_start_rdy_i;
   logic             unit_getResult_en_o;
   logic             unit_getResult_rdy_i;
   logic [W-1:0]     unit_getResult_data_i;
   logic             busy_o;
   logic [1:0]       owner_o;

   // requester / consumer / unit agents
   logic [N-1:0]     rq_en = '0;
   logic [N-1:0]     hold_mask = '0;
   logic [N-1:0]     take = '0;
   logic [W-1:0]     rq_dat [N];
   logic             u_srdy = 1'b0;
   logic             u_busy = 1'b0;
   int               u_cnt = 0;
   logic [W-1:0]     u_val = '0;
   int               u_dmax = 0;

   // reference model: phase 0 = no job, 1 = job at unit, 2 = result offered
   int               m_st = 0;
   int               m_ptr = 0;
   int               m_owner = 0;
   logic [W-1:0]     m_res = '0;

   int               tests = 0;
   int               fails = 0;
   int               glog[$];
   bit               rnd_mode = 1'b0;
   int               p_req = 50, p_take = 50, p_srdy = 70;
   int               c0;
   int               exp_ord [6] = '{0, 1, 3, 0, 1, 3};

   always #5 clk_i = ~clk_i;

   always_comb begin
      req_start_data_i = '0;
      for (int k = 0; k < N; k++) req_start_data_i[k*W +: W] = rq_dat[k];
   end

   assign req_start_en_i        = rq_en;
   assign req_getResult_en_i    = take;
   assign unit_start_rdy_i      = u_srdy;
   assign unit_getResult_rdy_i  = u_busy && (u_cnt == 0);
   assign unit_getResult_data_i = u_val;

   job_arbiter #(.DATA_WIDTH(W), .NUM_REQ(N)) dut (
      .clk_i                 (clk_i),
      .rst_i                 (rst_i),
      .req_start_en_i        (req_start_en_i),
      .req_start_data_i      (req_start_data_i),
      .req_start_rdy_o       (req_start_rdy_o),
      .req_getResult_en_i    (req_getResult_en_i),
      .req_getResult_rdy_o   (req_getResult_rdy_o),
      .req_getResult_data_o  (req_getResult_data_o),
      .unit_start_en_o       (unit_start_en_o),
      .unit_start_data_o     (unit_start_data_o),
      .unit_start_rdy_i      (unit_start_rdy_i),
      .unit_getResult_en_o   (unit_getResult_en_o),
      .unit_getResult_rdy_i  (unit_getResult_rdy_i),
      .unit_getResult_data_i (unit_getResult_data_i),
      .busy_o                (busy_o),
      .owner_o               (owner_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int winner(input logic [N-1:0] en, input int p);
      for (int i = 0; i < N; i++) begin
         int k = (p + i) % N;
         if (en[k]) return k;
      end
      return -1;
   endfunction

   // One clock cycle: drive at negedge, check at negedge+1, advance model at next negedge.
   task automatic step();
      int w;
      bit g, urdy, utake, ustart, tk;
      logic [N-1:0] hs;
      logic [W-1:0] udata;
      rq_en = rq_en | hold_mask;
      if (rnd_mode) begin
         for (int k = 0; k < N; k++) begin
            if (!rq_en[k] && ($urandom % 100 < p_req)) begin
               rq_en[k]  = 1'b1;
               rq_dat[k] = $urandom;
            end
         end
         take   = ($urandom % 100 < p_take) ? N'($urandom) : '0;
         u_srdy = ($urandom % 100 < p_srdy);
      end
      #1;
      w    = winner(rq_en, m_ptr);
      g    = (m_st == 0) && u_srdy && (w >= 0);
      urdy = unit_getResult_rdy_i;
      tk   = (m_st == 2) && take[m_owner];
      chk("start_rdy", 64'(req_start_rdy_o), g ? 64'(1 << w) : 64'(0));
      chk("unit_start_en", 64'(unit_start_en_o), 64'(g));
      if (g) chk("unit_start_data", 64'(unit_start_data_o), 64'(rq_dat[w]));
      chk("unit_get_en", 64'(unit_getResult_en_o), 64'((m_st == 1) && urdy));
      chk("busy", 64'(busy_o), 64'(m_st != 0));
      chk("owner", 64'(owner_o), 64'(m_owner));
      chk("get_rdy", 64'(req_getResult_rdy_o), (m_st == 2) ? 64'(1 << m_owner) : 64'(0));
      chk("get_data", 64'(req_getResult_data_o), 64'(m_res));
      hs     = req_start_rdy_o & rq_en;
      utake  = unit_getResult_en_o && unit_getResult_rdy_i;
      ustart = unit_start_en_o && u_srdy;
      udata  = unit_start_data_o;
      for (int k = 0; k < N; k++) if (hs[k]) glog.push_back(k);
      @(posedge clk_i);
      @(negedge clk_i);
      if (g) begin
         m_owner = w;
         m_ptr   = (w + 1) % N;
         m_st    = 1;
      end else if ((m_st == 1) && urdy) begin
         m_res = u_val;
         m_st  = 2;
      end else if (tk) begin
         m_st = 0;
      end
      rq_en = rq_en & ~hs;
      if (utake) u_busy = 1'b0;
      else if (u_busy && u_cnt > 0) u_cnt--;
      if (ustart) begin
         u_busy = 1'b1;
         u_cnt  = (u_dmax > 0) ? int'($urandom % (u_dmax + 1)) : 0;
         u_val  = udata + 1;
      end
   endtask

   // Reset pulse starting at a negedge: outputs must drop while rst_i is high.
   task automatic reset_dut();
      rst_i = 1'b1;
      #1;
      chk("rst_busy", 64'(busy_o), 64'(0));
      chk("rst_owner", 64'(owner_o), 64'(0));
      chk("rst_get_rdy", 64'(req_getResult_rdy_o), 64'(0));
      chk("rst_get_data", 64'(req_getResult_data_o), 64'(0));
      chk("rst_start_rdy", 64'(req_start_rdy_o), 64'(0));
      chk("rst_unit_start_en", 64'(unit_start_en_o), 64'(0));
      chk("rst_unit_get_en", 64'(unit_getResult_en_o), 64'(0));
      m_st = 0; m_ptr = 0; m_owner = 0; m_res = '0;
      u_busy = 1'b0; u_cnt = 0;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      take = '1;
      while (((m_st != 0) || (rq_en != '0)) && n < 40) begin
         step();
         n++;
      end
      chk("drain_done", 64'((m_st == 0) && (rq_en == '0)), 64'(1));
      take = '0;
   endtask

   initial begin
      rst_i = 1'b1;
      for (int k = 0; k < N; k++) rq_dat[k] = '0;
      @(negedge clk_i);
      reset_dut();

      // single request, minimum latency
      u_srdy = 1'b1;
      rq_dat[2] = 32'h0000_00AA;
      rq_en = 4'b0100;
      step();
      step();
      chk("single_get_rdy", 64'(req_getResult_rdy_o), 64'(4'b0100));
      chk("single_data", 64'(req_getResult_data_o), 64'(32'h0000_00AB));
      chk("single_owner", 64'(owner_o), 64'(2));
      take = 4'b0100;
      step();
      take = '0;

      // contention among 0, 1, 3 from a fresh pointer
      reset_dut();
      glog.delete();
      rq_dat[0] = 32'h10; rq_dat[1] = 32'h20; rq_dat[3] = 32'h30;
      hold_mask = 4'b1011;
      take = '1;
      for (int n = 0; n < 40 && glog.size() < 6; n++) step();
      chk("contention_count", 64'(glog.size() >= 6), 64'(1));
      for (int i = 0; i < 6 && i < glog.size(); i++) chk("contention_order", 64'(glog[i]), 64'(exp_ord[i]));
      hold_mask = '0;
      rq_en = '0;
      drain();

      // unit stall with requests 1 and 3 pending, pointer at 0
      u_srdy = 1'b0;
      rq_en = 4'b1010;
      c0 = glog.size();
      repeat (5) step();
      chk("stall_no_grant", 64'(glog.size()), 64'(c0));
      u_srdy = 1'b1;
      step();
      chk("stall_grant_count", 64'(glog.size()), 64'(c0 + 1));
      if (glog.size() > c0) chk("stall_grant_idx", 64'(glog[glog.size()-1]), 64'(1));

      // late consumer: owner 1 withholds, strays from others
      step();
      c0 = glog.size();
      take = 4'b1101;
      repeat (10) step();
      chk("late_busy", 64'(busy_o), 64'(1));
      chk("late_no_grant", 64'(glog.size()), 64'(c0));
      chk("late_data", 64'(req_getResult_data_o), 64'(32'h21));
      take = 4'b0010;
      step();
      take = '0;
      step();
      chk("late_next_grant", 64'(glog[glog.size()-1]), 64'(3));
      drain();

      // stray takes while idle
      take = '1;
      repeat (3) step();
      take = '0;

      // reset while a job is at the unit
      rq_dat[0] = 32'h55;
      rq_en = 4'b0001;
      u_srdy = 1'b1;
      step();
      reset_dut();
      rq_en = 4'b1001;
      c0 = glog.size();
      step();
      chk("post_rst_grant_count", 64'(glog.size()), 64'(c0 + 1));
      if (glog.size() > c0) chk("post_rst_grant_idx", 64'(glog[glog.size()-1]), 64'(0));
      drain();

      // randomized traffic
      rnd_mode = 1'b1;
      u_dmax = 3;
      for (int blk = 0; blk < 6; blk++) begin
         p_req  = $urandom_range(5, 90);
         p_take = $urandom_range(10, 90);
         p_srdy = $urandom_range(20, 100);
         for (int n = 0; n < 500; n++) begin
            if ($urandom % 400 == 0) reset_dut();
            else step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/job_arbiter.md
JOB_ARBITER -- requirements
Module: job_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the job operand/result width in bits.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, giving the requester count; legal range is 2..16.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_start_en_i, input, NUM_REQ bits: per-requester job request, held with data stable until accepted.
REQ-006 The block SHALL have port req_start_data_i, input, NUM_REQ*DATA_WIDTH bits: operand of requester k in slice [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 The block SHALL have port req_start_rdy_o, output, NUM_REQ bits: one-hot or zero accept; request k transfers when bit k of en and rdy are both high.
REQ-008 The block SHALL have port req_getResult_en_i, input, NUM_REQ bits: per-requester result take.
REQ-009 The block SHALL have port req_getResult_rdy_o, output, NUM_REQ bits: one-hot or zero, registered; result available to that requester.
REQ-010 The block SHALL have port req_getResult_data_o, output, DATA_WIDTH bits: shared registered result bus.
REQ-011 The block SHALL have port unit_start_en_o, output, 1 bit: issue a job to the shared unit.
REQ-012 The block SHALL have port unit_start_data_o, output, DATA_WIDTH bits: operand to the unit.
REQ-013 The block SHALL have port unit_start_rdy_i, input, 1 bit: unit can accept a job.
REQ-014 The block SHALL have port unit_getResult_en_o, output, 1 bit: take the unit's result.
REQ-015 The block SHALL have port unit_getResult_rdy_i, input, 1 bit: unit result valid.
REQ-016 The block SHALL have port unit_getResult_data_i, input, DATA_WIDTH bits: unit result.
REQ-017 The block SHALL have port busy_o, output, 1 bit, registered: a job is in flight or undelivered.
REQ-018 The block SHALL have port owner_o, output, clog2(NUM_REQ) bits, registered: requester index of the current job.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, BUSY and DONE; one job at most is in flight.
REQ-020 In IDLE, the winner SHALL be the first requester with start_en high, searching from index ptr upward modulo NUM_REQ.
REQ-021 In IDLE with a winner w and unit_start_rdy_i high, the block SHALL drive combinationally: req_start_rdy_o = one-hot(w), unit_start_en_o = 1, unit_start_data_o = slice w.
REQ-022 In the cycle of REQ-021, the block SHALL, on the next edge, set owner <= w and ptr <= (w+1) mod NUM_REQ, and move to BUSY.
REQ-023 In IDLE with no request or with unit_start_rdy_i low, all start rdy outputs and unit_start_en_o SHALL be 0, ptr SHALL be unchanged, and state SHALL stay IDLE.
REQ-024 In BUSY, unit_getResult_en_o SHALL equal unit_getResult_rdy_i; when that is high, the block SHALL capture the result into the result register and move to DONE.
REQ-025 In BUSY and DONE, req_start_rdy_o and unit_start_en_o SHALL be 0; pending requests wait without loss.
REQ-026 In DONE, req_getResult_rdy_o SHALL be one-hot(owner) and req_getResult_data_o SHALL be the captured result.
REQ-027 In DONE, req_getResult_en_i[owner] high SHALL clear rdy and move to IDLE on the next edge.
REQ-028 getResult_en from a non-owner, and getResult_en in any state other than DONE, SHALL be ignored.
REQ-029 busy_o SHALL be 1 in BUSY and DONE and 0 in IDLE.
REQ-030 Minimum latency SHALL be: accept at cycle T, unit result ready at T+1, and req_getResult_rdy_o high from T+2.
REQ-031 Back-to-back operation SHALL allow a new grant in the first IDLE cycle after delivery; that is, delivery at cycle D allows a grant at D+1.
REQ-032 req_getResult_data_o SHALL hold its last value outside DONE.

Reset
REQ-033 rst_i high SHALL immediately force state IDLE, ptr 0, owner 0, result register 0, and all registered outputs 0.
REQ-034 Reset mid-job SHALL abandon the job with no result delivered; unit-side recovery is the unit's own reset.
REQ-035 After rst_i deasserts, the first grant SHALL be possible on the first rising edge.

Verification
REQ-036 Single request: NUM_REQ=4, req 2 en with data 0x0000_00AA, unit rdy always, unit returns data+1 one cycle later -> rdy_o[2] at T, result 0x0000_00AB on rdy bit 2 at T+2, owner_o=2.
REQ-037 Contention: reqs 0, 1 and 3 held continuously -> grant order 0,1,3,0,... with ptr wrapping from 3 to 0, and no request dropped.
REQ-038 Unit stall: unit_start_rdy_i low for 5 cycles with req 1 pending -> no rdy_o and ptr unchanged; grant occurs in the first cycle rdy rises.
REQ-039 Late consumer: owner withholds getResult_en for 10 cycles -> rdy and data held stable, busy_o=1, and other requests not granted.
REQ-040 Reset mid-BUSY: rst_i pulse -> state IDLE and all outputs 0 immediately; the next request is granted from ptr 0.
REQ-041 Stray take: non-owner getResult_en pulsed in DONE and in IDLE -> no state change.
